// File: rtl/delta_accumulate.sv
// rtl/delta_accumulate.sv - delta-to-sample reconstruction with saturation and frame tracking
// One registered output stage; the output register doubles as the running accumulator.
module delta_accumulate #(
  parameter int DWIDTH    = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              out_sat,
  output logic              out_abort
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [DWIDTH-1:0] MAX_VAL = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic {
    EXPECT_FIRST = 1'b0,
    IN_FRAME     = 1'b1
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]     idx, idx_next;
  logic              accept;
  logic              restart;
  logic              abort_next;
  logic [DWIDTH:0]   sum;
  logic              clamp;
  logic [DWIDTH-1:0] acc_next;
  logic              sat_next;
  logic              last_next;

  // Ready depends only on the output slot, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EXPECT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = last_next ? EXPECT_FIRST : IN_FRAME;
    end
  end

  always_comb begin
    restart    = 1'b0;
    abort_next = 1'b0;
    case (state)
      EXPECT_FIRST: restart = 1'b1;
      IN_FRAME: begin
        restart    = in_first;
        abort_next = in_first;
      end
      default: restart = 1'b1;
    endcase
  end

  // One extra bit of headroom exposes overflow as a disagreement of the top two bits.
  always_comb begin
    sum      = {out_data[DWIDTH-1], out_data} + {in_data[DWIDTH-1], in_data};
    clamp    = sum[DWIDTH] ^ sum[DWIDTH-1];
    acc_next = sum[DWIDTH-1:0];
    if (clamp) begin
      acc_next = sum[DWIDTH] ? MIN_VAL : MAX_VAL;
    end
    sat_next = out_sat || clamp;
    idx_next = idx + IW'(1);
    if (restart) begin
      acc_next = in_data;
      sat_next = 1'b0;
      idx_next = '0;
    end
    last_next = (idx_next == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      out_abort <= 1'b0;
      idx       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= acc_next;
        out_last  <= last_next;
        out_sat   <= sat_next;
        out_abort <= abort_next;
        idx       <= idx_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delta_accumulate.sv
// tb/tb_delta_accumulate.sv - directed and randomized checks of delta_accumulate against a scoreboard model
module tb_delta_accumulate;

  localparam int DW   = 16;
  localparam int FL   = 4;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_sat;
  logic          out_abort;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int data;
    bit last;
    bit sat;
    bit abort;
  } exp_t;

  exp_t q[$];
  bit   m_in_frame = 1'b0;
  int   m_acc      = 0;
  int   m_cnt      = 0;
  bit   m_sat      = 1'b0;

  delta_accumulate #(.DWIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .out_abort (out_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: expected samples are queued on input transfers and retired on output transfers.
  always @(negedge clk) begin : sb
    exp_t e;
    exp_t n;
    int   d;
    int   s;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", $signed(out_data), 0);
      check("rst_in_ready", in_ready, 1);
      q.delete();
      m_in_frame = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
      check("occupancy", out_valid, q.size());
      if (out_valid && q.size() > 0) begin
        e = q[0];
        check("sb_data", $signed(out_data), e.data);
        check("sb_last", out_last, e.last);
        check("sb_sat", out_sat, e.sat);
        check("sb_abort", out_abort, e.abort);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        d = $signed(in_data);
        n.abort = 1'b0;
        if (!m_in_frame || in_first) begin
          n.abort = m_in_frame && in_first;
          m_acc   = d;
          m_cnt   = 0;
          m_sat   = 1'b0;
        end else begin
          s = m_acc + d;
          if (s > MAXV) begin
            s = MAXV;
            m_sat = 1'b1;
          end else if (s < MINV) begin
            s = MINV;
            m_sat = 1'b1;
          end
          m_acc = s;
          m_cnt++;
        end
        n.data     = m_acc;
        n.sat      = m_sat;
        n.last     = (m_cnt == FL - 1);
        m_in_frame = !n.last;
        q.push_back(n);
      end
    end
  end

  task automatic send(input int d, input bit f);
    bit took;
    took     = 1'b0;
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    in_first = f;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int d, input bit l, input bit s, input bit a);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, $signed(out_data), d);
    check({tag, "_last"}, out_last, l);
    check({tag, "_sat"}, out_sat, s);
    check({tag, "_abort"}, out_abort, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", $signed(out_data), 0);
    check("reset_last", out_last, 0);
    check("reset_sat", out_sat, 0);
    check("reset_abort", out_abort, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic reconstruction, back to back
    send(100, 0); expect_out("basic0", 100, 0, 0, 0);
    send(-30, 0); expect_out("basic1", 70, 0, 0, 0);
    send(5, 0);   expect_out("basic2", 75, 0, 0, 0);
    send(7, 0);   expect_out("basic3", 82, 1, 0, 0);

    // positive saturation and sticky flag
    send(32000, 0); expect_out("psat0", 32000, 0, 0, 0);
    send(1000, 0);  expect_out("psat1", 32767, 0, 1, 0);
    send(-10, 0);   expect_out("psat2", 32757, 0, 1, 0);
    send(0, 0);     expect_out("psat3", 32757, 1, 1, 0);

    // in_first at a normal frame start: no abort, sat cleared; negative saturation
    send(-32768, 1); expect_out("nsat0", -32768, 0, 0, 0);
    send(-1, 0);     expect_out("nsat1", -32768, 0, 1, 0);
    send(0, 0);      expect_out("nsat2", -32768, 0, 1, 0);
    send(3, 0);      expect_out("nsat3", -32765, 1, 1, 0);

    // backpressure
    send(10, 0); expect_out("stall0", 10, 0, 0, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd20;
    in_first  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_data", $signed(out_data), 10);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("stall1", 30, 0, 0, 0);
    send(1, 0); expect_out("stall2", 31, 0, 0, 0);
    send(1, 0); expect_out("stall3", 32, 1, 0, 0);

    // abort mid-frame
    send(1, 0);   expect_out("abort0", 1, 0, 0, 0);
    send(2, 0);   expect_out("abort1", 3, 0, 0, 0);
    send(500, 1); expect_out("abort2", 500, 0, 0, 1);
    send(1, 0);   expect_out("abort3", 501, 0, 0, 0);
    send(1, 0);   expect_out("abort4", 502, 0, 0, 0);
    send(1, 0);   expect_out("abort5", 503, 1, 0, 0);

    // reset mid-frame
    send(4, 0); expect_out("mrst0", 4, 0, 0, 0);
    send(5, 0); expect_out("mrst1", 9, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_data", $signed(out_data), 0);
    check("mrst_last", out_last, 0);
    check("mrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(9, 0); expect_out("mrst2", 9, 0, 0, 0);
    send(1, 0); expect_out("mrst3", 10, 0, 0, 0);
    send(1, 0); expect_out("mrst4", 11, 0, 0, 0);
    send(1, 0); expect_out("mrst5", 12, 1, 0, 0);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 999) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_first  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) in_data = DW'($urandom);
      else in_data = DW'($urandom_range(0, 400)) - DW'(200);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
